addsub_serial_n: RTL and testbench

- Parametrised, digit-serial signed/unsigned adder-subtractor.
- Processes W bits per clock over N/W cycles, then reports sum, carry, overflow and zero/negative flags.
- Valid/ready handshake on both input and output, so it sits between a register-file read stage and a writeback stage.
- Successor to the combinational N-bit subtractor: mode-selectable add/sub, status flags, smaller area per bit.

---
 rtl/addsub_serial_n.sv | 120 ++++++++++++
 tb/tb_addsub_serial_n.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_n.sv
// Digit-serial add/subtract with status flags. It handles W bits per clock over N/W cycles and
// uses valid/ready on both sides. Define ADDSUB_SAT_EN to saturate the sum on signed overflow.
module addsub_serial_n #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int unsigned Digits = N / W;
    localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
    localparam logic [CntW-1:0] LastDigit = CntW'(Digits - 1);

`ifdef ADDSUB_SAT_EN
    localparam logic [N-1:0] One    = 1;
    localparam logic [N-1:0] SatMin = One << (N - 1);
    localparam logic [N-1:0] SatMax = ~SatMin;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [N-1:0]    a_q, b_q, s_q;
    logic            carry_q;
    logic [CntW-1:0] cnt_q;

    logic [W-1:0] a_dig, b_dig, s_dig;
    logic         carry_nxt, msb_cin, ovf_nxt;
    logic [N-1:0] s_nxt, res_nxt;

    always_comb begin
        a_dig = a_q[cnt_q*W +: W];
        b_dig = b_q[cnt_q*W +: W];
        {carry_nxt, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{W{1'b0}}, carry_q};
        // On the last digit this is the carry into bit N-1.
        msb_cin = a_dig[W-1] ^ b_dig[W-1] ^ s_dig[W-1];
        ovf_nxt = msb_cin ^ carry_nxt;
        s_nxt = s_q;
        s_nxt[cnt_q*W +: W] = s_dig;
        res_nxt = s_nxt;
`ifdef ADDSUB_SAT_EN
        if (ovf_nxt) begin
            res_nxt = a_q[N-1] ? SatMin : SatMax;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid && o_ready) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        o_ready <= 1'b0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    s_q     <= s_nxt;
                    carry_q <= carry_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastDigit) begin
                        cnt_q    <= '0;
                        o_valid  <= 1'b1;
                        sum      <= res_nxt;
                        c_out    <= carry_nxt;
                        overflow <= ovf_nxt;
                        zero     <= (res_nxt == '0);
                        negative <= res_nxt[N-1];
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_n.sv
// Testbench for addsub_serial_n: a 32-bit DUT with W=8, plus three 8-bit DUTs with W=1, 4 and 8,
// all checked against an arithmetic model.
module tb_addsub_serial_n;

    typedef struct packed {
        logic [31:0] sum;
        logic        cy;
        logic        ov;
        logic        zf;
        logic        nf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, i_valid, o_ready, i_ready, sub, o_valid;
    logic        c_out, overflow, zero, negative;
    logic [31:0] a, b, sum;

    logic [2:0]  s_oready, s_ovalid, s_c, s_v, s_z, s_n;
    logic        s_ivalid, s_sub;
    logic [7:0]  s_a, s_b;
    logic [7:0]  s_sum [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    exp_t exp8;

    always #5 clk = ~clk;

    addsub_serial_n #(.N(32), .W(8)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .a(a), .b(b), .sub(sub),
        .o_valid(o_valid), .i_ready(i_ready), .sum(sum), .c_out(c_out), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SW = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        addsub_serial_n #(.N(8), .W(SW)) u_dut8 (
            .clk(clk), .rst(rst), .i_valid(s_ivalid), .o_ready(s_oready[g]), .a(s_a), .b(s_b),
            .sub(s_sub), .o_valid(s_ovalid[g]), .i_ready(1'b1), .sum(s_sum[g]), .c_out(s_c[g]),
            .overflow(s_v[g]), .zero(s_z[g]), .negative(s_n[g])
        );
    end

    // Reference: plain modular and signed-integer arithmetic on nb-bit operands.
    function automatic exp_t model(input int nb, input longint unsigned ma,
                                   input longint unsigned mb, input bit msub);
        exp_t e;
        longint unsigned mask, half, u;
        longint sa, sb, r;
        mask = (64'd1 << nb) - 64'd1;
        half = 64'd1 << (nb - 1);
        u = msub ? (ma + ((~mb) & mask) + 64'd1) : (ma + mb);
        sa = (ma >= half) ? longint'(ma) - longint'(mask) - 64'sd1 : longint'(ma);
        sb = (mb >= half) ? longint'(mb) - longint'(mask) - 64'sd1 : longint'(mb);
        r = msub ? (sa - sb) : (sa + sb);
        e.ov = (r > longint'(half) - 64'sd1) || (r < -longint'(half));
        e.cy = u[nb];
        e.sum = 32'(u & mask);
`ifdef ADDSUB_SAT_EN
        if (e.ov) e.sum = 32'((r > 0) ? (half - 64'd1) : half);
`endif
        e.zf = (e.sum == 32'd0);
        e.nf = e.sum[nb-1];
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Compare process: every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check1("spurious_o_valid", o_valid, 1'b0);
            end else begin
                check32("cmp_sum", sum, exp_q[0].sum);
                check1("cmp_c_out", c_out, exp_q[0].cy);
                check1("cmp_overflow", overflow, exp_q[0].ov);
                check1("cmp_zero", zero, exp_q[0].zf);
                check1("cmp_negative", negative, exp_q[0].nf);
                if (i_ready) void'(exp_q.pop_front());
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (!rst && s_ovalid[g]) begin
                check32("cmp8_sum", {24'd0, s_sum[g]}, {24'd0, exp8.sum[7:0]});
                check1("cmp8_c_out", s_c[g], exp8.cy);
                check1("cmp8_overflow", s_v[g], exp8.ov);
                check1("cmp8_zero", s_z[g], exp8.zf);
                check1("cmp8_negative", s_n[g], exp8.nf);
            end
        end
    end

    task automatic wait_idle();
        int c = 0;
        while (!o_ready && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check1("idle_before_issue", o_ready, 1'b1);
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                         input logic [31:0] esum, input logic ec, input logic ev,
                         input logic ez, input logic en, input int hold);
        int lat;
        wait_idle();
        a = ta; b = tb; sub = tsub; i_valid = 1'b1; i_ready = (hold == 0);
        exp_q.push_back(model(32, 64'(ta), 64'(tb), tsub));
        @(posedge clk); #1;
        // Operand changes while busy must be ignored.
        i_valid = 1'b0; a = $urandom; b = $urandom; sub = ~tsub;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check32("latency", 32'(lat), 32'd4);
        check32("lit_sum", sum, esum);
        check1("lit_c_out", c_out, ec);
        check1("lit_overflow", overflow, ev);
        check1("lit_zero", zero, ez);
        check1("lit_negative", negative, en);
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            @(posedge clk); #1;
            check1("bp_o_ready", o_ready, 1'b0);
            check1("bp_o_valid", o_valid, 1'b1);
            check32("bp_sum", sum, esum);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        check1("post_o_valid", o_valid, 1'b0);
        check1("post_o_ready", o_ready, 1'b1);
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub);
        int lat[3];
        bit seen[3];
        int c = 0;
        while (s_oready != 3'b111 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check1("sweep_idle", &s_oready, 1'b1);
        exp8 = model(8, 64'(ta), 64'(tb), tsub);
        s_a = ta; s_b = tb; s_sub = tsub; s_ivalid = 1'b1;
        @(posedge clk); #1;
        s_ivalid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            lat[g] = 0;
            seen[g] = 1'b0;
        end
        for (c = 1; c <= 20 && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) begin
                if (s_ovalid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    lat[g] = c;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            check32("sweep_latency", 32'(lat[g]), (g == 0) ? 32'd8 : ((g == 1) ? 32'd2 : 32'd1));
        end
    endtask

    initial begin
        exp_t pin;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        s_ivalid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; exp8 = '0;

        // Pin the model with hand-computed results.
        pin = model(32, 64'd3, 64'd5, 1'b1);
        check32("model_pin_sub", pin.sum, 32'hFFFF_FFFE);
        check1("model_pin_borrow", pin.cy, 1'b0);
        pin = model(8, 64'h80, 64'h01, 1'b1);
        check1("model_pin_ovf8", pin.ov, 1'b1);
        check1("model_pin_c8", pin.cy, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check1("rst_o_ready", o_ready, 1'b1);
        check1("rst_o_valid", o_valid, 1'b0);
        check32("rst_sum", sum, 32'd0);
        check1("rst_flags", c_out | overflow | zero | negative, 1'b0);
        rst = 1'b0;

        run32(32'd5, 32'd3, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run32(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run32(32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
`ifdef ADDSUB_SAT_EN
        run32(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run32(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
`else
        run32(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        run32(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
`endif
        run32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Backpressure: hold i_ready low for 10 cycles while i_valid is pending.
        run32(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        repeat (6) @(posedge clk);
        #1;
        check1("bp_no_accept", o_ready, 1'b1);

        // Reset during the second BUSY cycle discards the operation.
        wait_idle();
        a = 32'd100; b = 32'd200; sub = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("midrst_o_ready", o_ready, 1'b1);
        check1("midrst_o_valid", o_valid, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
            check1("midrst_no_pulse", o_valid, 1'b0);
        end
        run32(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Sweep of the 8-bit digit widths.
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'h80, 8'h01, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h00, 8'h01, 1'b1);
        run8(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end
        repeat (12) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
